key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_MS, 20, number of consecutive stable 1 ms samples required to accept a change.
- HOLD_MS, 800, press duration before the first auto-repeat pulse.
- REPEAT_MS, 200, interval between subsequent auto-repeat pulses.
- ACTIVE_LOW, 1, when 1 a raw input of 0 means pressed.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous active-high reset.
- key_in  in  N_KEYS  raw asynchronous button/switch inputs.
- key_level  out  N_KEYS  debounced pressed state, 1 = pressed.
- key_press  out  N_KEYS  one-clk pulse on each accepted press.
- key_release  out  N_KEYS  one-clk pulse on each accepted release.
- key_repeat  out  N_KEYS  one-clk auto-repeat pulses while a key is held.
REQ-003 The block SHALL use one clock (clk); reset SHALL be synchronous and active-high (rst); there SHALL be no other clock or asynchronous reset.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 Each key_in bit SHALL pass through a 2-flop synchronizer, then be normalised to pressed=1 per ACTIVE_LOW; this gives sample[i].
REQ-006 A shared prescaler SHALL count 0..CLK_HZ/1000-1 and assert an internal tick for exactly one clk at the terminal count, then wrap to 0.
REQ-007 Each channel SHALL hold a stable counter (width ceil(log2(DEBOUNCE_MS+1))); on a tick it SHALL increment if sample != key_level, or clear to 0 if sample == key_level; it SHALL not change between ticks.
REQ-008 On the tick where the counter equals DEBOUNCE_MS-1 and sample != key_level still holds, the following happens at the next clk edge:
- key_level toggles.
- The counter clears.
- key_press (for 0->1) or key_release (for 1->0) asserts for exactly one clk.
REQ-009 A glitch shorter than DEBOUNCE_MS consecutive ticks SHALL produce no change on any output.
REQ-010 Each channel SHALL hold a hold counter that counts ticks while key_level=1 and clears when key_level=0.
REQ-011 key_repeat SHALL pulse for one clk when the hold counter reaches HOLD_MS ticks, and every REPEAT_MS ticks after that, for as long as key_level=1.
REQ-012 The hold counter SHALL not overflow: after the first repeat it reloads to HOLD_MS-REPEAT_MS (or cycles modulo REPEAT_MS).
REQ-013 key_press and key_repeat SHALL never assert in the same clk for the same channel.
REQ-014 Channels SHALL be fully independent; simultaneous events on several keys SHALL each produce their own pulses in the same cycle.
REQ-015 A release mid-hold SHALL suppress any further key_repeat immediately and produce exactly one key_release.

Reset
REQ-016 While rst=1 at a clk edge, the following SHALL apply:
- All synchronizer flops load the inactive level.
- The prescaler, stable counters and hold counters load 0.
- key_level, key_press, key_release and key_repeat load 0.
REQ-017 A key held through reset deassertion SHALL be reported as a fresh press after DEBOUNCE_MS ticks (about DEBOUNCE_MS ms plus synchronizer latency).
REQ-018 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse emitted.

Verification
All scenarios use CLK_HZ=10_000 (tick every 10 clk), DEBOUNCE_MS=4, HOLD_MS=10, REPEAT_MS=5, ACTIVE_LOW=1.
REQ-019 Clean press: key_in[0] 1->0 and held -> key_press[0] is a single-cycle pulse; key_level[0]=1 between 40 and 52 clk after the input edge; no key_release.
REQ-020 Bounce: key_in[1] toggles every 7 clk for 60 clk, then stays 0 -> exactly one key_press[1], about 40 clk after the final transition; zero pulses during the bounce.
REQ-021 Auto-repeat: key_in[2] held low for 300 clk -> one key_press; first key_repeat 100 clk after key_level rises, then every 50 clk; on release, one key_release and no further key_repeat.
REQ-022 Simultaneous: key_in[0] and key_in[3] fall on the same clk -> key_press[0] and key_press[3] assert in the same cycle.
REQ-023 Reset mid-hold: key_in[1] held, rst=1 for 3 clk at 70 clk after key_level rises -> all outputs 0 on the first clk edge with rst=1; after rst falls, a new key_press[1] follows the debounce window and no key_repeat precedes it.

Source files
------------

// File: rtl/key_debounce.sv
// Multi-key debouncer: 2-flop synchronizer, shared 1 ms tick, per-key stable
// counter, and press/release/auto-repeat pulse generation. All outputs registered.
module key_debounce #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned HOLD_MS     = 800,
  parameter int unsigned REPEAT_MS   = 200,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int unsigned TICK_DIV = CLK_HZ / 1000;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam int unsigned HW       = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_MS - REPEAT_MS);
  localparam logic          INV         = (ACTIVE_LOW != 0);
  localparam logic [N_KEYS-1:0] IDLE_RAW = {N_KEYS{INV}};

  logic [PW-1:0]     r_presc;
  logic [N_KEYS-1:0] r_sync1, r_sync2;
  logic [N_KEYS-1:0] r_level, r_press, r_release, r_repeat;
  logic [SW-1:0]     r_stable [N_KEYS];
  logic [HW-1:0]     r_hold   [N_KEYS];

  logic              w_tick;
  logic [N_KEYS-1:0] w_sample;
  logic [N_KEYS-1:0] w_level_nx, w_press_nx, w_release_nx, w_repeat_nx;
  logic [SW-1:0]     w_stable_nx [N_KEYS];
  logic [HW-1:0]     w_hold_nx   [N_KEYS];

  assign w_tick   = (r_presc == PRESC_LAST);
  assign w_sample = r_sync2 ^ {N_KEYS{INV}};

  always_comb begin
    w_level_nx   = r_level;
    w_press_nx   = '0;
    w_release_nx = '0;
    w_repeat_nx  = '0;
    w_stable_nx  = r_stable;
    w_hold_nx    = r_hold;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      if (w_tick) begin
        if (w_sample[i] != r_level[i]) begin
          if (r_stable[i] == STABLE_LAST) begin
            w_level_nx[i]   = ~r_level[i];
            w_stable_nx[i]  = '0;
            w_press_nx[i]   = ~r_level[i];
            w_release_nx[i] = r_level[i];
          end else begin
            w_stable_nx[i] = r_stable[i] + SW'(1);
          end
        end else begin
          w_stable_nx[i] = '0;
        end
      end
      // A release on this tick wins over a repeat falling due on the same tick.
      if (!r_level[i] || w_release_nx[i]) begin
        w_hold_nx[i] = '0;
      end else if (w_tick) begin
        if (r_hold[i] == HOLD_LAST) begin
          w_repeat_nx[i] = 1'b1;
          w_hold_nx[i]   = HOLD_RELOAD;
        end else begin
          w_hold_nx[i] = r_hold[i] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_sync1   <= IDLE_RAW;
      r_sync2   <= IDLE_RAW;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_stable[i] <= '0;
        r_hold[i]   <= '0;
      end
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + PW'(1);
      r_sync1   <= key_in;
      r_sync2   <= r_sync1;
      r_level   <= w_level_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_repeat  <= w_repeat_nx;
      r_stable  <= w_stable_nx;
      r_hold    <= w_hold_nx;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_repeat  = r_repeat;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: vector table for steady-state behaviour plus
// hand-timed sequences for latency, bounce, auto-repeat and reset-mid-hold.
module tb_key_debounce;
  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  key_debounce #(
    .CLK_HZ(10_000), .N_KEYS(NK), .DEBOUNCE_MS(4),
    .HOLD_MS(10), .REPEAT_MS(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; a 1 ms tick lands on every edge with cyc%10==0.
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int n_press[NK], n_rel[NK], n_rep[NK], t_press[NK];
  int t_rep2[$];
  int n_dbl = 0, n_clash = 0;
  logic [NK-1:0] p_press = '0, p_rel = '0, p_rep = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NK; i++) begin
      if (key_press[i]) begin
        n_press[i] <= n_press[i] + 1;
        t_press[i] <= cyc;
      end
      if (key_release[i]) n_rel[i] <= n_rel[i] + 1;
      if (key_repeat[i])  n_rep[i] <= n_rep[i] + 1;
    end
    if (key_repeat[2]) t_rep2.push_back(cyc);
    if (|((key_press & p_press) | (key_release & p_rel) | (key_repeat & p_rep))) n_dbl <= n_dbl + 1;
    if (|(key_press & key_repeat)) n_clash <= n_clash + 1;
    p_press <= key_press;
    p_rel   <= key_release;
    p_rep   <= key_repeat;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lvl(input int ch, input logic v, input string nm);
    int k = 0;
    while (key_level[ch] !== v && k < 100) begin
      step();
      k++;
    end
    chk(nm, int'(key_level[ch] === v), 1);
  endtask

  // Drive on the next call so the input is captured on an edge with cyc%10==9.
  task automatic wait_phase();
    while (cyc % 10 != 8) step();
  endtask

  typedef struct {
    logic [NK-1:0]      keys;
    int                 cycles;
    logic [NK-1:0]      lvl;
    logic [NK-1:0][3:0] dp, dr, dk;
  } vec_t;

  vec_t vt[10];

  initial begin
    int bp, br, bk, tr, tf, f, t0, rep_at;
    int cp[NK], cr[NK], ck[NK];

    vt[0] = '{4'b1111, 60, 4'b0000, 16'h0000, 16'h0001, 16'h0000};
    vt[1] = '{4'b0110, 60, 4'b1001, 16'h1001, 16'h0000, 16'h0000};
    vt[2] = '{4'b1111, 60, 4'b0000, 16'h0000, 16'h1001, 16'h0000};
    vt[3] = '{4'b1101, 25, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vt[4] = '{4'b1111, 40, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vt[5] = '{4'b0101, 15, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vt[6] = '{4'b1111, 40, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
    vt[7] = '{4'b0111, 60, 4'b1000, 16'h1000, 16'h0000, 16'h0000};
    vt[8] = '{4'b1011, 60, 4'b0100, 16'h0100, 16'h1000, 16'h0000};
    vt[9] = '{4'b1111, 60, 4'b0000, 16'h0000, 16'h0100, 16'h0000};

    // Reset state
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset outputs", int'({key_level, key_press, key_release, key_repeat}), 0);
    end
    rst = 1'b0;
    repeat (20) step();
    chk("idle level", int'(key_level), 0);
    chk("idle pulses", n_press[0] + n_press[1] + n_press[2] + n_press[3] + n_rel[0] + n_rep[0], 0);

    // Clean press on key 0, worst-case tick phase
    wait_phase();
    key_in[0] = 1'b0;
    t0 = cyc + 1;
    wait_lvl(0, 1'b1, "clean press level");
    chk_rng("clean press latency", cyc - t0, 40, 52);
    repeat (5) step();
    chk("clean press count", n_press[0], 1);
    chk("clean press no release", n_rel[0], 0);

    // Table vectors
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NK; i++) begin
        cp[i] = n_press[i];
        cr[i] = n_rel[i];
        ck[i] = n_rep[i];
      end
      key_in = vt[v].keys;
      repeat (vt[v].cycles) step();
      chk($sformatf("vec%0d level", v), int'(key_level), int'(vt[v].lvl));
      for (int i = 0; i < NK; i++) begin
        chk($sformatf("vec%0d press[%0d]", v, i), n_press[i] - cp[i], int'(vt[v].dp[i]));
        chk($sformatf("vec%0d release[%0d]", v, i), n_rel[i] - cr[i], int'(vt[v].dr[i]));
        chk($sformatf("vec%0d repeat[%0d]", v, i), n_rep[i] - ck[i], int'(vt[v].dk[i]));
      end
      if (v == 1) chk("simultaneous press cycle k3 vs k0", t_press[3], t_press[0]);
    end

    // Bounce on key 1: toggle every 7 clk, final transition to pressed
    wait_phase();
    bp = n_press[1];
    br = n_rel[1];
    for (int k = 0; k < 8; k++) begin
      key_in[1] = ~key_in[1];
      repeat (7) step();
    end
    chk("bounce no press", n_press[1] - bp, 0);
    chk("bounce no release", n_rel[1] - br, 0);
    chk("bounce level", int'(key_level[1]), 0);
    key_in[1] = 1'b0;
    tf = cyc + 1;
    wait_lvl(1, 1'b1, "bounce settle level");
    chk_rng("bounce press latency", cyc - tf, 30, 52);
    repeat (2) step();
    chk("bounce press count", n_press[1] - bp, 1);
    key_in[1] = 1'b1;
    repeat (60) step();
    chk("bounce release count", n_rel[1] - br, 1);

    // Auto-repeat on key 2, held 300 clk
    wait_phase();
    bp = n_press[2];
    br = n_rel[2];
    bk = n_rep[2];
    t_rep2.delete();
    key_in[2] = 1'b0;
    f = cyc + 1;
    wait_lvl(2, 1'b1, "repeat press level");
    tr = cyc;
    chk_rng("repeat press latency", tr - f, 40, 52);
    while (cyc < f + 299) step();
    key_in[2] = 1'b1;
    wait_lvl(2, 1'b0, "repeat release level");
    tf = cyc;
    rep_at = n_rep[2];
    repeat (120) step();
    chk("repeat press count", n_press[2] - bp, 1);
    chk("repeat release count", n_rel[2] - br, 1);
    chk("repeat pulse count", n_rep[2] - bk, 4);
    chk("repeat none after release", n_rep[2] - rep_at, 0);
    chk("repeat release time", tf - tr, 300);
    for (int k = 0; k < 4; k++)
      chk($sformatf("repeat%0d offset", k), (k < t_rep2.size()) ? t_rep2[k] - tr : -1, 100 + 50 * k);

    // Reset mid-hold on key 1
    wait_phase();
    key_in[1] = 1'b0;
    wait_lvl(1, 1'b1, "rst-hold press level");
    repeat (70) step();
    bk = n_rep[1];
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid-hold reset outputs %0d", k), int'({key_level, key_press, key_release, key_repeat}), 0);
    end
    rst = 1'b0;
    bp = n_press[1];
    br = n_rel[1];
    wait_lvl(1, 1'b1, "post-reset press level");
    chk("post-reset press cycle", t_press[1], 40);
    chk("post-reset press count", n_press[1] - bp, 1);
    chk("post-reset no release", n_rel[1] - br, 0);
    chk("post-reset no repeat", n_rep[1] - bk, 0);
    key_in[1] = 1'b1;
    repeat (60) step();
    chk("post-reset release count", n_rel[1] - br, 1);

    chk("multi-cycle pulses", n_dbl, 0);
    chk("press/repeat same cycle", n_clash, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
